adda_sequencer: RTL

Sample-rate sequencer for the 8-bit ADC/DAC add-on port. It generates the ADC and DAC conversion clocks from `i_clk` with a programmable divider. It captures ADC words after the converter's pipeline latency and produces bursts of valid samples. It selects what the DAC is driven with: constant, ramp, loopback, or loopback AND ramp. It sits between the top-level pins (`AD_PORT`/`DA_PORT`, ADCLK/DACLK) and the downstream sample consumer.

---
 rtl/adda_sequencer.sv | 107 ++++++++++
 1 files changed

// File: rtl/adda_sequencer.sv
// adda_sequencer: ADC/DAC conversion-clock generator, burst sample capture and DAC source select.
module adda_sequencer #(
  parameter int CNT_W   = 16,
  parameter int DIV_W   = 8,
  parameter int ADC_LAT = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic [1:0]       i_mode,
  input  logic [DIV_W-1:0] i_div,
  input  logic [CNT_W-1:0] i_burst_len,
  input  logic [7:0]       i_const,
  input  logic [7:0]       i_adc_data,
  output logic             o_adc_clk,
  output logic             o_dac_clk,
  output logic [7:0]       o_dac_data,
  output logic [7:0]       o_sample,
  output logic             o_sample_valid,
  output logic             o_busy,
  output logic             o_done
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;

  logic [1:0]       state_q, state_d, mode_q, mode_d;
  logic [DIV_W-1:0] phase_q, phase_d, div_q, div_d;
  logic [CNT_W-1:0] len_q, len_d, cap_cnt_q, cap_cnt_d, vcnt_q, vcnt_d;
  logic [7:0]       const_q, const_d, ramp_q, ramp_d, dac_q, dac_d, sample_q, sample_d;
  logic [7:0]       ramp_n, src;
  logic             valid_q, valid_d, done_q, done_d, adc_clk_q, adc_clk_d;
  logic             idle, start, abort, tick, fill_end, run_tick;

  always_comb begin
    idle      = state_q == IDLE;
    start     = idle && i_start && !i_stop;
    abort     = !idle && i_stop;
    tick      = !idle && phase_q == div_q;
    fill_end  = state_q == FILL && tick && cap_cnt_q + CNT_W'(1) == CNT_W'(ADC_LAT);
    run_tick  = state_q == RUN && tick && !i_stop;
    ramp_n    = ramp_q + 8'd1;
    // the word captured on this tick feeds the next period's DAC value
    src       = mode_q == 2'd0 ? const_q :
                mode_q == 2'd1 ? ramp_n :
                mode_q == 2'd2 ? i_adc_data : i_adc_data & ramp_n;
    state_d   = start ? (ADC_LAT == 0 ? RUN : FILL) :
                (abort || (state_q == RUN && done_q)) ? IDLE :
                fill_end ? RUN : state_q;
    div_d     = start ? (i_div == '0 ? DIV_W'(1) : i_div) : div_q;
    mode_d    = start ? i_mode : mode_q;
    len_d     = start ? i_burst_len : len_q;
    const_d   = start ? i_const : const_q;
    phase_d   = (state_d == IDLE || idle || tick) ? '0 : phase_q + DIV_W'(1);
    ramp_d    = start ? 8'd0 : tick ? ramp_n : ramp_q;
    cap_cnt_d = start ? '0 : (state_q == FILL && tick) ? cap_cnt_q + CNT_W'(1) : cap_cnt_q;
    vcnt_d    = start ? '0 : run_tick ? vcnt_q + CNT_W'(1) : vcnt_q;
    valid_d   = run_tick;
    done_d    = run_tick && len_q != '0 && vcnt_q + CNT_W'(1) == len_q;
    sample_d  = run_tick ? i_adc_data : sample_q;
    dac_d     = start ? (i_mode == 2'd0 ? i_const : 8'd0) : (tick && !i_stop) ? src : dac_q;
    adc_clk_d = state_d != IDLE && phase_d <= (div_d >> 1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      mode_q    <= 2'd0;
      phase_q   <= '0;
      div_q     <= DIV_W'(1);
      len_q     <= '0;
      cap_cnt_q <= '0;
      vcnt_q    <= '0;
      const_q   <= 8'd0;
      ramp_q    <= 8'd0;
      dac_q     <= 8'd0;
      sample_q  <= 8'd0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      adc_clk_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      phase_q   <= phase_d;
      div_q     <= div_d;
      len_q     <= len_d;
      cap_cnt_q <= cap_cnt_d;
      vcnt_q    <= vcnt_d;
      const_q   <= const_d;
      ramp_q    <= ramp_d;
      dac_q     <= dac_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      adc_clk_q <= adc_clk_d;
    end
  end

  assign o_busy         = !idle;
  assign o_adc_clk      = adc_clk_q;
  assign o_dac_clk      = !idle && !adc_clk_q;
  assign o_dac_data     = dac_q;
  assign o_sample       = sample_q;
  assign o_sample_valid = valid_q;
  assign o_done         = done_q;
endmodule
